full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Bit-level full adder, scalable to a WIDTH-bit ripple-carry adder, with combinational sum/carry outputs plus a registered copy of the result.
- Leaf arithmetic cell of the Adders library. Instantiated directly by higher adder structures (ripple, carry-select) and by unit benches.
- Combinational path is the primary function. The registered path provides a pipelined tap for timing-closed integration.

Parameters:
- WIDTH, 1, operand width in bits; default 1 is the classic 1-bit full adder.

Ports:
- clk_i  input  1  clock, rising-edge; used only by the registered outputs
- rst_i  input  1  asynchronous, active-high reset; clears registered outputs only
- A_i  input  WIDTH  operand A
- B_i  input  WIDTH  operand B
- C_i  input  1  carry-in
- S_o  output  WIDTH  combinational sum
- C_o  output  1  combinational carry-out
- S_q_o  output  WIDTH  registered sum, one-cycle latency
- C_q_o  output  1  registered carry-out, one-cycle latency

Interface notes:
- One clock; reset is asynchronous and active-high. Ports are named clk_i / rst_i.
- clk_i, rst_i, S_q_o and C_q_o may be left unconnected when only the combinational function is used. S_o/C_o must still be correct in that case.

Behaviour:
- Per-bit cell k, with carry chain c[0] = C_i:
  - s[k] = A_i[k] XOR B_i[k] XOR c[k]
  - c[k+1] = (A_i[k] AND B_i[k]) OR (A_i[k] AND c[k]) OR (B_i[k] AND c[k])
- S_o = s[WIDTH-1:0] and C_o = c[WIDTH].
- Equivalent arithmetic: {C_o, S_o} = A_i + B_i + C_i, evaluated at WIDTH+1 bits, unsigned, with no truncation of the carry.
- S_o/C_o are purely combinational: no latch, no clock dependency, and they settle within the same simulation delta after any input change.
- Registered path:
  - On each rising clk_i edge with rst_i low: S_q_o <= S_o, C_q_o <= C_o.
  - Latency is exactly 1 cycle; there is no enable and the registers update every cycle.
- Reset:
  - While rst_i is high, S_q_o = 0 and C_q_o = 0 immediately, independent of clk_i.
  - Reset asserted mid-operation clears the registers at once. The combinational outputs are unaffected by reset at all times.
  - Release: the first rising edge after rst_i falls captures the current combinational result.
- X-propagation: no masking logic. Unknown inputs propagate naturally.
- Boundary conditions:
  - All-ones operands with C_i=1 give S_o = all-ones, C_o = 1.
  - All-zero operands give zero outputs.
  - Carry must ripple the full WIDTH, e.g. A = all-ones, B = 0, C_i = 1 gives S_o = 0, C_o = 1.
- No state machine; no handshake.

Test Plan:
- Exhaustive 1-bit truth table, WIDTH=1, all 8 {A_i,B_i,C_i} combinations 000..111, 10 time units each:
  - 000 -> S_o=0, C_o=0
  - 100 -> 1,0
  - 010 -> 1,0
  - 110 -> 0,1
  - 001 -> 1,0
  - 101 -> 0,1
  - 011 -> 0,1
  - 111 -> 1,1
- Combinational-only use: clk_i/rst_i left floating, same 8 vectors -> S_o/C_o still match the truth table.
- Registered path: rst_i=1 then released; apply A=1, B=1, C_i=1 -> S_q_o=0, C_q_o=0 until the next rising edge, then S_q_o=1, C_q_o=1.
- Async reset mid-run: S_q_o=1 held, rst_i pulsed between clock edges -> S_q_o, C_q_o drop to 0 immediately; S_o/C_o unchanged.
- WIDTH=8 full carry ripple: A=8'hFF, B=8'h00, C_i=1 -> S_o=8'h00, C_o=1.
- WIDTH=8 random: 1000 random A, B, C_i -> {C_o,S_o} equals the 9-bit A+B+C_i. The registered outputs match the previous cycle's combinational result.

Source files
------------

// File: rtl/full_adder.sv
// full_adder
//   WIDTH-bit ripple-carry adder built from per-bit full-adder cells, with a
//   combinational result and a registered copy of that result.
//   WIDTH = 1 (default) is the classic 1-bit full adder.
//
// Ports
//   clk_i  : rising-edge clock, drives only the registered outputs
//   rst_i  : asynchronous active-high reset, clears the registered outputs only
//   A_i    : operand A [WIDTH]
//   B_i    : operand B [WIDTH]
//   C_i    : carry-in
//   S_o    : combinational sum [WIDTH]
//   C_o    : combinational carry-out
//   S_q_o  : registered sum, one-cycle latency [WIDTH]
//   C_q_o  : registered carry-out, one-cycle latency
//
// The combinational outputs never depend on clk_i/rst_i, so the registered
// ports may be left unconnected when only the adder function is needed.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic [WIDTH-1:0] S_q_o,
    output logic             C_q_o
);

    // Carry chain: c[0] is the carry-in, c[WIDTH] the carry-out.
    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        S_o  = '0;
        c[0] = C_i;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            S_o[k]  = A_i[k] ^ B_i[k] ^ c[k];
            c[k+1]  = (A_i[k] & B_i[k]) | (A_i[k] & c[k]) | (B_i[k] & c[k]);
        end
        C_o = c[WIDTH];
    end

    // Pipelined tap: free-running, no enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            S_q_o <= '0;
            C_q_o <= 1'b0;
        end else begin
            S_q_o <= S_o;
            C_q_o <= C_o;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic       clk;
    logic       rst;

    // 1-bit instance, fully connected
    logic       a1, b1, c1;
    logic       s1, co1, sq1, cq1;

    // 1-bit instance used combinationally only: clock/reset never driven
    logic       fclk, frst;
    logic       s1c, co1c, sq1c, cq1c;

    // 8-bit instance
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8, sq8;
    logic       co8, cq8;

    int total;
    int bad;

    full_adder #(.WIDTH(1)) u1 (
        .clk_i(clk), .rst_i(rst), .A_i(a1), .B_i(b1), .C_i(c1),
        .S_o(s1), .C_o(co1), .S_q_o(sq1), .C_q_o(cq1)
    );

    full_adder #(.WIDTH(1)) u1c (
        .clk_i(fclk), .rst_i(frst), .A_i(a1), .B_i(b1), .C_i(c1),
        .S_o(s1c), .C_o(co1c), .S_q_o(sq1c), .C_q_o(cq1c)
    );

    full_adder #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .A_i(a8), .B_i(b8), .C_i(c8),
        .S_o(s8), .C_o(co8), .S_q_o(sq8), .C_q_o(cq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic a;
        logic b;
        logic ci;
        logic s;
        logic co;
    } vec_t;

    vec_t tbl[8];

    logic [8:0] exp9;
    logic [8:0] prev9;

    initial begin
        total = 0;
        bad   = 0;

        // Truth table written out independently of the adder equations.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = '0;   b8 = '0;   c8 = 1'b0;

        #1;
        check("reset_sq1", {15'd0, sq1}, 16'd0);
        check("reset_cq1", {15'd0, cq1}, 16'd0);
        check("reset_sq8", {8'd0, sq8},  16'd0);
        check("reset_cq8", {15'd0, cq8}, 16'd0);

        // Exhaustive 1-bit table on both the clocked and the floating-clock instance.
        for (int i = 0; i < 8; i++) begin
            a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].ci;
            #1;
            check("tt_s",       {15'd0, s1},   {15'd0, tbl[i].s});
            check("tt_co",      {15'd0, co1},  {15'd0, tbl[i].co});
            check("tt_comb_s",  {15'd0, s1c},  {15'd0, tbl[i].s});
            check("tt_comb_co", {15'd0, co1c}, {15'd0, tbl[i].co});
            #9;
        end

        // Registered path: inputs 1,1,1 held during reset, then released mid-cycle.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        #1;
        check("reg_in_reset_sq", {15'd0, sq1}, 16'd0);
        check("reg_in_reset_cq", {15'd0, cq1}, 16'd0);
        rst = 1'b0;
        #1;
        check("reg_released_sq", {15'd0, sq1}, 16'd0);
        check("reg_released_cq", {15'd0, cq1}, 16'd0);
        @(posedge clk);
        #1;
        check("reg_capture_sq", {15'd0, sq1}, 16'd1);
        check("reg_capture_cq", {15'd0, cq1}, 16'd1);

        // Asynchronous reset pulsed between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sq", {15'd0, sq1}, 16'd0);
        check("async_rst_cq", {15'd0, cq1}, 16'd0);
        check("async_rst_s",  {15'd0, s1},  16'd1);
        check("async_rst_co", {15'd0, co1}, 16'd1);
        @(negedge clk);
        rst = 1'b0;

        // 8-bit boundaries.
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        check("w8_ones_s",  {8'd0, s8},   16'h00FF);
        check("w8_ones_co", {15'd0, co8}, 16'd1);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        #1;
        check("w8_zero_s",  {8'd0, s8},   16'h0000);
        check("w8_zero_co", {15'd0, co8}, 16'd0);
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #1;
        check("w8_ripple_s",  {8'd0, s8},   16'h0000);
        check("w8_ripple_co", {15'd0, co8}, 16'd1);
        prev9 = 9'h100;

        // Random 8-bit vectors against plain 9-bit arithmetic; registered
        // outputs must equal the result from the previous cycle.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("w8_reg", {7'd0, cq8, sq8}, {7'd0, prev9});
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            exp9 = 9'(a8) + 9'(b8) + 9'(c8);
            #1;
            check("w8_rand", {7'd0, co8, s8}, {7'd0, exp9});
            prev9 = exp9;
        end
        @(negedge clk);
        check("w8_reg_last", {7'd0, cq8, sq8}, {7'd0, prev9});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
